// File: rtl/acc_byte_unloader.sv
// Accumulator read-out: snapshots a finished MAC result and streams it LSB-first as bytes.
// Latency: first beat valid the cycle after acc_done; NB cycles per result with out_ready high.
// Backpressure: out_ready low holds the current beat stable; results arriving mid-stream are dropped and flagged.
module acc_byte_unloader #(
  parameter int ACC_W  = 22,
  parameter int BYTE_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ACC_W-1:0]  acc_in,
  input  logic              acc_done,
  output logic              acc_clr,
  output logic              busy,
  output logic [BYTE_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              overrun,
  input  logic              ovr_clr
);

  // Beats per result is derived from the widths and cannot be overridden.
  localparam int NB    = (ACC_W + BYTE_W - 1) / BYTE_W;
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
  localparam int PAD_W = NB * BYTE_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [ACC_W-1:0]    shadow_q, shadow_d;
  logic                acc_clr_q, acc_clr_d;
  logic                overrun_q, overrun_d;

  logic [PAD_W-1:0]    padded;
  logic [BYTE_W-1:0]   cur_byte;
  logic                sending;
  logic                is_last;
  logic                fire;

  // Zero-extend the snapshot so the top beat carries zeros above the MSB.
  assign padded = PAD_W'(shadow_q);

  // Select the beat addressed by the current index.
  always_comb begin
    cur_byte = '0;
    for (int i = 0; i < NB; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_byte = padded[i*BYTE_W +: BYTE_W];
      end
    end
  end

  assign sending = (state_q == SEND);
  assign is_last = (idx_q == LAST_IDX);
  assign fire    = sending && out_ready;

  // Next-state logic: accept, stream, back-to-back re-arm and overrun tracking.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    shadow_d  = shadow_q;
    acc_clr_d = 1'b0;
    overrun_d = overrun_q;

    // A clear only takes effect if no new drop happens in the same cycle.
    if (ovr_clr) begin
      overrun_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (acc_done) begin
          shadow_d  = acc_in;
          idx_d     = '0;
          acc_clr_d = 1'b1;
          state_d   = SEND;
        end
      end
      SEND: begin
        if (fire && is_last) begin
          idx_d = '0;
          if (acc_done) begin
            // Last beat leaves as the next result arrives: take it with no bubble.
            shadow_d  = acc_in;
            acc_clr_d = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          if (fire) begin
            idx_d = idx_q + 1'b1;
          end
          if (acc_done) begin
            // No room for this result; the accumulator is not cleared so the host can tell.
            overrun_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // State and datapath registers; reset abandons any partial result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      shadow_q  <= '0;
      acc_clr_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      acc_clr_q <= acc_clr_d;
      overrun_q <= overrun_d;
    end
  end

  assign acc_clr   = acc_clr_q;
  assign busy      = sending;
  assign out_valid = sending;
  assign out_last  = sending && is_last;
  assign out_data  = sending ? cur_byte : '0;
  assign overrun   = overrun_q;

endmodule
